// File: rtl/config_pkg.sv
// config_pkg
// Core configuration record type. Only the fields this slice of the
// codebase consumes are carried: virtual address width and return
// address stack depth.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;      // virtual address width in bits
        int unsigned RASDepth;  // return address stack entries
    } cva6_cfg_t;

endpackage

// File: rtl/cva6_config_pkg.sv
// cva6_config_pkg
// Default core configuration instance used as the parameter default by
// blocks that take a config_pkg::cva6_cfg_t.
package cva6_config_pkg;

    localparam config_pkg::cva6_cfg_t cva6_cfg = '{
        VLEN:     32'd32,
        RASDepth: 32'd2
    };

endpackage

// File: rtl/ras_pkg.sv
// ras_pkg
// Shared types and constants for the return address stack.
//   ras_entry_t : one stack entry (return address, default-config VLEN)
//   RAS_STAT_W  : width of the optional overflow/underflow statistics
package ras_pkg;

    localparam int unsigned RAS_VLEN   = cva6_config_pkg::cva6_cfg.VLEN;
    localparam int unsigned RAS_STAT_W = 16;

    typedef logic [RAS_VLEN-1:0] ras_entry_t;

endpackage

// File: rtl/ras_sat_ctr.sv
// ras_sat_ctr
// Saturating up-counter used for the return address stack statistics.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset, clears the count
//   i_inc  : count one event this cycle
//   o_cnt  : current count, holds at all-ones once reached
module ras_sat_ctr #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ras_circ_stack.sv
// ras_circ_stack
// Return address stack built as a circular buffer. A push on a full stack
// overwrites the oldest entry; a pop on an empty stack is ignored. Outputs
// come straight from registers, so a push/pop is visible one cycle later.
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset (clears entries too)
//   flush_i        : discard all entries; wins over push/pop
//   push_i         : call seen, push push_addr_i
//   push_addr_i    : return address to push (VLEN bits)
//   pop_i          : return seen, pop top entry
//   top_valid_o    : stack non-empty
//   top_addr_o     : entry at top of stack
//   empty_o        : count == 0
//   full_o         : count == DEPTH
// Optional (macro RAS_STATS_EN defined):
//   overflow_cnt_o : saturating count of pushes that overwrote the oldest entry
//   underflow_cnt_o: saturating count of pops issued while empty
//   Neither counter is cleared by flush_i.
module ras_circ_stack
    import ras_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg,
    parameter int unsigned DEPTH = CVA6Cfg.RASDepth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [CVA6Cfg.VLEN-1:0] push_addr_i,
    input  logic                    pop_i,
    output logic                    top_valid_o,
    output logic [CVA6Cfg.VLEN-1:0] top_addr_o,
    output logic                    empty_o,
    output logic                    full_o
`ifdef RAS_STATS_EN
    ,
    output logic [RAS_STAT_W-1:0]   overflow_cnt_o,
    output logic [RAS_STAT_W-1:0]   underflow_cnt_o
`endif
);

    localparam int unsigned VLEN  = CVA6Cfg.VLEN;
    localparam int unsigned TOS_W = (DEPTH == 1) ? 1 : $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [TOS_W-1:0] TOS_LAST = TOS_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [VLEN-1:0]  r_entry [DEPTH];
    logic [TOS_W-1:0] r_tos;
    logic [CNT_W-1:0] r_count;

    logic [TOS_W-1:0] w_tos_inc;
    logic [TOS_W-1:0] w_tos_dec;
    logic             w_empty;
    logic             w_full;

    // Modulo-DEPTH pointer steps; DEPTH need not be a power of two.
    assign w_tos_inc = (r_tos == TOS_LAST) ? '0 : r_tos + 1'b1;
    assign w_tos_dec = (r_tos == '0) ? TOS_LAST : r_tos - 1'b1;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tos   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (flush_i) begin
            // Entries are left as-is; count == 0 hides them.
            r_tos   <= '0;
            r_count <= '0;
        end else if (push_i && pop_i && !w_empty) begin
            // Return immediately followed by a call: replace the top in place.
            r_entry[r_tos] <= push_addr_i;
        end else if (push_i) begin
            // Plain push, or push+pop on an empty stack which degenerates to one.
            r_tos              <= w_tos_inc;
            r_entry[w_tos_inc] <= push_addr_i;
            if (!w_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop_i && !w_empty) begin
            r_tos   <= w_tos_dec;
            r_count <= r_count - 1'b1;
        end
    end

    assign top_addr_o  = r_entry[r_tos];
    assign top_valid_o = !w_empty;
    assign empty_o     = w_empty;
    assign full_o      = w_full;

`ifdef RAS_STATS_EN
    logic w_overflow;
    logic w_underflow;

    assign w_overflow  = !flush_i && push_i && !pop_i && w_full;
    assign w_underflow = !flush_i && pop_i && !push_i && w_empty;

    ras_sat_ctr #(.W(RAS_STAT_W)) u_overflow_ctr (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_inc (w_overflow),
        .o_cnt (overflow_cnt_o)
    );

    ras_sat_ctr #(.W(RAS_STAT_W)) u_underflow_ctr (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_inc (w_underflow),
        .o_cnt (underflow_cnt_o)
    );
`endif

endmodule

// File: tb/tb_ras_circ_stack.sv
// tb_ras_circ_stack
// Directed bench for ras_circ_stack at DEPTH = 2, VLEN = 32.
// Statistics outputs are checked only when RAS_STATS_EN is defined.
module tb_ras_circ_stack;
    import ras_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        push_i;
    logic [31:0] push_addr_i;
    logic        pop_i;
    logic        top_valid_o;
    logic [31:0] top_addr_o;
    logic        empty_o;
    logic        full_o;
`ifdef RAS_STATS_EN
    logic [15:0] overflow_cnt_o;
    logic [15:0] underflow_cnt_o;
`endif

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk_i = ~clk_i;

    ras_circ_stack dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .push_addr_i (push_addr_i),
        .pop_i       (pop_i),
        .top_valid_o (top_valid_o),
        .top_addr_o  (top_addr_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
`ifdef RAS_STATS_EN
        ,
        .overflow_cnt_o  (overflow_cnt_o),
        .underflow_cnt_o (underflow_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic [31:0] a, input logic q, input logic f);
        push_i      = p;
        push_addr_i = a;
        pop_i       = q;
        flush_i     = f;
        @(posedge clk_i);
        #1;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        ras_entry_t a0;
        rst_i = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
        #2;
        check("rst_valid", {31'd0, top_valid_o}, 32'd0);
        check("rst_addr",  top_addr_o,           32'd0);
        check("rst_empty", {31'd0, empty_o},     32'd1);
        check("rst_full",  {31'd0, full_o},      32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;

        // push 0x100, 0x200, pop
        cyc(1, 32'h100, 0, 0);
        check("p1_addr",  top_addr_o,           32'h100);
        check("p1_valid", {31'd0, top_valid_o}, 32'd1);
        check("p1_full",  {31'd0, full_o},      32'd0);
        cyc(1, 32'h200, 0, 0);
        check("p2_addr",  top_addr_o,           32'h200);
        check("p2_full",  {31'd0, full_o},      32'd1);
        cyc(0, 32'h0, 1, 0);
        check("pop1_addr",  top_addr_o,       32'h100);
        check("pop1_full",  {31'd0, full_o},  32'd0);
        check("pop1_empty", {31'd0, empty_o}, 32'd0);
        cyc(0, 32'h0, 1, 0);
        check("pop2_empty", {31'd0, empty_o}, 32'd1);

        // overflow: 0x100, 0x200, 0x300 then pop twice
        cyc(1, 32'h100, 0, 0);
        cyc(1, 32'h200, 0, 0);
        cyc(1, 32'h300, 0, 0);
        check("ov_top",  top_addr_o,          32'h300);
        check("ov_full", {31'd0, full_o},     32'd1);
`ifdef RAS_STATS_EN
        check("ov_cnt", {16'd0, overflow_cnt_o}, 32'd1);
`endif
        cyc(0, 32'h0, 1, 0);
        check("ov_pop1", top_addr_o, 32'h200);
        cyc(0, 32'h0, 1, 0);
        check("ov_pop2_empty", {31'd0, empty_o},     32'd1);
        check("ov_pop2_valid", {31'd0, top_valid_o}, 32'd0);

        // underflow: tos stays at entry 1 which still holds 0x300
        cyc(0, 32'h0, 1, 0);
        check("uf_empty", {31'd0, empty_o},     32'd1);
        check("uf_valid", {31'd0, top_valid_o}, 32'd0);
        check("uf_addr",  top_addr_o,           32'h300);
`ifdef RAS_STATS_EN
        check("uf_cnt", {16'd0, underflow_cnt_o}, 32'd1);
        check("uf_ov_hold", {16'd0, overflow_cnt_o}, 32'd1);
`endif

        // push+pop with count 1, then with count 0
        cyc(1, 32'h100, 0, 0);
        cyc(1, 32'h400, 1, 0);
        check("pp1_addr",  top_addr_o,           32'h400);
        check("pp1_valid", {31'd0, top_valid_o}, 32'd1);
        check("pp1_full",  {31'd0, full_o},      32'd0);
        cyc(0, 32'h0, 1, 0);
        check("pp1_popempty", {31'd0, empty_o}, 32'd1);
        cyc(1, 32'h500, 1, 0);
        check("pp0_addr",  top_addr_o,           32'h500);
        check("pp0_valid", {31'd0, top_valid_o}, 32'd1);
        check("pp0_full",  {31'd0, full_o},      32'd0);

        // flush beats a simultaneous push
        cyc(1, 32'h111, 0, 0);
        check("fl_pre_full", {31'd0, full_o}, 32'd1);
        cyc(1, 32'h600, 0, 1);
        check("fl_empty", {31'd0, empty_o},     32'd1);
        check("fl_full",  {31'd0, full_o},      32'd0);
        check("fl_valid", {31'd0, top_valid_o}, 32'd0);
`ifdef RAS_STATS_EN
        check("fl_ov_kept", {16'd0, overflow_cnt_o}, 32'd1);
`endif
        cyc(1, 32'h800, 0, 0);
        check("fl_push_addr", top_addr_o,      32'h800);
        check("fl_push_full", {31'd0, full_o}, 32'd0);

        // async reset between edges while pushing; entry 0 holds 0x900 before it
        cyc(1, 32'h900, 0, 0);
        push_i = 1'b1; push_addr_i = 32'hA00;
        #3;
        rst_i = 1'b1;
        #1;
        check("ar_valid", {31'd0, top_valid_o}, 32'd0);
        check("ar_addr",  top_addr_o,           32'd0);
        check("ar_empty", {31'd0, empty_o},     32'd1);
        check("ar_full",  {31'd0, full_o},      32'd0);
`ifdef RAS_STATS_EN
        check("ar_uf_cnt", {16'd0, underflow_cnt_o}, 32'd0);
`endif
        @(posedge clk_i); #1;
        check("ar_hold_valid", {31'd0, top_valid_o}, 32'd0);
        push_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;
        cyc(1, 32'h700, 0, 0);
        check("ar_push_addr",  top_addr_o,           32'h700);
        check("ar_push_valid", {31'd0, top_valid_o}, 32'd1);
        // popping exposes entry 0, which reset must have cleared
        cyc(0, 32'h0, 1, 0);
        a0 = top_addr_o;
        check("ar_entry0_clear", a0,                32'd0);
        check("ar_pop_empty",    {31'd0, empty_o}, 32'd1);

`ifdef RAS_STATS_EN
        // underflow counter saturation
        pop_i = 1'b1;
        repeat (65540) @(posedge clk_i);
        #1;
        pop_i = 1'b0;
        check("uf_sat", {16'd0, underflow_cnt_o}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
